// File: rtl/riscv_v_pkg.sv
// Shared vector-config constants: geometry, vtype field layout, op and FSM encodings.
package riscv_v_pkg;

   localparam int unsigned VLEN     = 128;
   localparam int unsigned ELEN     = 64;
   localparam int unsigned MAX_LMUL = 8;
   // Largest vl: SEW=8 with LMUL=MAX_LMUL.
   localparam int unsigned MAX_VLEN = VLEN * MAX_LMUL / 8;
   localparam int unsigned VL_W     = $clog2(MAX_VLEN) + 1;
   localparam int unsigned VSEW_MAX = $clog2(ELEN / 8);

   localparam int unsigned VTYPE_W   = 9;
   localparam int unsigned VLMUL_LSB = 0;
   localparam int unsigned VSEW_LSB  = 3;
   localparam int unsigned VTA_BIT   = 6;
   localparam int unsigned VMA_BIT   = 7;
   localparam int unsigned VILL_BIT  = 8;

   localparam logic [VTYPE_W-1:0] VTYPE_VILL = 9'h100;
   localparam logic [VTYPE_W-1:0] VTYPE_RST  = 9'h0C0;
   localparam logic [VL_W-1:0]    VL_RST     = VL_W'(16);

   typedef enum logic [1:0] {
      OP_VSETVLI  = 2'b00,
      OP_VSETIVLI = 2'b01,
      OP_VSETVL   = 2'b10,
      OP_ILLEGAL  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_COMMIT,
      ST_RESP
   } state_e;

endpackage

// File: rtl/riscv_v_vlmax_calc.sv
// Combinational VLMAX and vill derivation from a candidate vtype.
module riscv_v_vlmax_calc
   import riscv_v_pkg::*;
(
   input  op_e             op,
   input  logic [2:0]      vsew,
   input  logic [2:0]      vlmul,
   input  logic            vill_bit,
   input  logic            rs2_hi_nz,
   output logic [VL_W-1:0] vlmax,
   output logic            vill
);

   localparam logic [VL_W-1:0] VLMAX_E8_M1 = VL_W'(VLEN / 8);

   logic [VL_W-1:0] base;

   always_comb begin
      base = VLMAX_E8_M1 >> vsew;
      case (vlmul)
         3'b000, 3'b001, 3'b010, 3'b011: vlmax = base << vlmul[1:0];
         3'b101:                         vlmax = base >> 3;
         3'b110:                         vlmax = base >> 2;
         3'b111:                         vlmax = base >> 1;
         default:                        vlmax = '0;
      endcase
      vill = (32'(vsew) > VSEW_MAX) || (vlmul == 3'b100) || (vlmax == '0) ||
             vill_bit || ((op == OP_VSETVL) && rs2_hi_nz) || (op == OP_ILLEGAL);
   end

endmodule

// File: rtl/riscv_v_vsetvl_unit.sv
// vsetvl/vsetvli/vsetivli execution: computes new vl/vtype, pulses CSR writes, returns vl to rd.
module riscv_v_vsetvl_unit
   import riscv_v_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [1:0]          req_op,
   input  logic                req_rd_x0,
   input  logic                req_rs1_x0,
   input  logic [31:0]         req_rs1_data,
   input  logic [4:0]          req_uimm,
   input  logic [VTYPE_W-1:0]  req_vtype_imm,
   input  logic [31:0]         req_rs2_data,
   input  logic [VL_W-1:0]     cur_vl,
   input  logic                flush,
   output logic                vl_wr_en,
   output logic [VL_W-1:0]     vl_data,
   output logic                vtype_wr_en,
   output logic [VTYPE_W-1:0]  vtype_data,
   output logic                vstart_wr_en,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic                resp_rd_wr_en,
   output logic [31:0]         resp_rd_data
);

   state_e               state;
   op_e                  op_q;
   logic                 rd_x0_q;
   logic                 rs1_x0_q;
   logic [31:0]          rs1_q;
   logic [4:0]           uimm_q;
   logic [VTYPE_W-1:0]   vtype_q;
   logic                 rs2_hi_q;
   logic [VL_W-1:0]      vlmax;
   logic                 vill;
   logic [31:0]          avl;
   logic [31:0]          vlmax_ext;
   logic [VL_W-1:0]      vl_new;

   riscv_v_vlmax_calc u_vlmax_calc (
      .op        (op_q),
      .vsew      (vtype_q[VSEW_LSB +: 3]),
      .vlmul     (vtype_q[VLMUL_LSB +: 3]),
      .vill_bit  (vtype_q[VILL_BIT]),
      .rs2_hi_nz (rs2_hi_q),
      .vlmax     (vlmax),
      .vill      (vill)
   );

   // AVL is compared at full 32-bit width so large rs1 values saturate to VLMAX.
   always_comb begin
      vlmax_ext = 32'(vlmax);
      if (op_q == OP_VSETIVLI)  avl = 32'(uimm_q);
      else if (!rs1_x0_q)       avl = rs1_q;
      else if (!rd_x0_q)        avl = vlmax_ext;
      else                      avl = 32'(cur_vl);
      if (vill)                 vl_new = '0;
      else if (avl < vlmax_ext) vl_new = avl[VL_W-1:0];
      else                      vl_new = vlmax;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         op_q          <= OP_VSETVLI;
         rd_x0_q       <= 1'b0;
         rs1_x0_q      <= 1'b0;
         rs1_q         <= '0;
         uimm_q        <= '0;
         vtype_q       <= '0;
         rs2_hi_q      <= 1'b0;
         vl_data       <= VL_RST;
         vtype_data    <= VTYPE_RST;
         resp_rd_data  <= '0;
         resp_rd_wr_en <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  op_q     <= op_e'(req_op);
                  rd_x0_q  <= req_rd_x0;
                  rs1_x0_q <= req_rs1_x0;
                  rs1_q    <= req_rs1_data;
                  uimm_q   <= req_uimm;
                  vtype_q  <= (op_e'(req_op) == OP_VSETVL) ? req_rs2_data[VTYPE_W-1:0]
                                                           : req_vtype_imm;
                  rs2_hi_q <= |req_rs2_data[31:8];
                  state    <= ST_CALC;
               end
            end
            ST_CALC: begin
               if (flush) begin
                  vl_data       <= VL_RST;
                  vtype_data    <= VTYPE_RST;
                  resp_rd_data  <= '0;
                  resp_rd_wr_en <= 1'b0;
                  state         <= ST_IDLE;
               end else begin
                  vl_data       <= vl_new;
                  vtype_data    <= vill ? VTYPE_VILL : vtype_q;
                  resp_rd_data  <= 32'(vl_new);
                  resp_rd_wr_en <= !rd_x0_q;
                  state         <= ST_COMMIT;
               end
            end
            ST_COMMIT: begin
               if (flush) begin
                  vl_data       <= VL_RST;
                  vtype_data    <= VTYPE_RST;
                  resp_rd_data  <= '0;
                  resp_rd_wr_en <= 1'b0;
                  state         <= ST_IDLE;
               end else begin
                  state <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (flush || resp_ready) state <= ST_IDLE;
            end
         endcase
      end
   end

   // Enables decode from state; flush gates them within the cycle it arrives.
   assign req_ready    = (state == ST_IDLE);
   assign vl_wr_en     = (state == ST_COMMIT) && !flush;
   assign vtype_wr_en  = (state == ST_COMMIT) && !flush;
   assign vstart_wr_en = (state == ST_COMMIT) && !flush;
   assign resp_valid   = (state == ST_RESP) && !flush;

endmodule

// File: tb/tb_riscv_v_vsetvl_unit.sv
// Directed vector table plus hand sequences for back-pressure, reset and flush.
module tb_riscv_v_vsetvl_unit;
   import riscv_v_pkg::*;

   logic                clk = 1'b0;
   logic                rst;
   logic                req_valid, req_ready;
   logic [1:0]          req_op;
   logic                req_rd_x0, req_rs1_x0;
   logic [31:0]         req_rs1_data, req_rs2_data;
   logic [4:0]          req_uimm;
   logic [8:0]          req_vtype_imm;
   logic [7:0]          cur_vl;
   logic                flush;
   logic                vl_wr_en, vtype_wr_en, vstart_wr_en;
   logic [7:0]          vl_data;
   logic [8:0]          vtype_data;
   logic                resp_valid, resp_ready, resp_rd_wr_en;
   logic [31:0]         resp_rd_data;

   riscv_v_vsetvl_unit dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_rd_x0(req_rd_x0), .req_rs1_x0(req_rs1_x0),
      .req_rs1_data(req_rs1_data), .req_uimm(req_uimm), .req_vtype_imm(req_vtype_imm),
      .req_rs2_data(req_rs2_data), .cur_vl(cur_vl), .flush(flush),
      .vl_wr_en(vl_wr_en), .vl_data(vl_data), .vtype_wr_en(vtype_wr_en),
      .vtype_data(vtype_data), .vstart_wr_en(vstart_wr_en), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .resp_rd_wr_en(resp_rd_wr_en), .resp_rd_data(resp_rd_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic        rd_x0;
      logic        rs1_x0;
      logic [31:0] rs1;
      logic [4:0]  uimm;
      logic [8:0]  imm;
      logic [31:0] rs2;
      logic [7:0]  cvl;
      logic [7:0]  evl;
      logic [8:0]  evt;
      logic        ewe;
   } vec_t;

   int checks = 0;
   int failures = 0;
   vec_t vecs[$];

   function automatic vec_t mk(logic [1:0] op, logic rd0, logic rs10, logic [31:0] rs1,
                               logic [4:0] uimm, logic [8:0] imm, logic [31:0] rs2,
                               logic [7:0] cvl, logic [7:0] evl, logic [8:0] evt, logic ewe);
      vec_t v;
      v.op = op; v.rd_x0 = rd0; v.rs1_x0 = rs10; v.rs1 = rs1; v.uimm = uimm;
      v.imm = imm; v.rs2 = rs2; v.cvl = cvl; v.evl = evl; v.evt = evt; v.ewe = ewe;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      req_op = v.op; req_rd_x0 = v.rd_x0; req_rs1_x0 = v.rs1_x0;
      req_rs1_data = v.rs1; req_uimm = v.uimm; req_vtype_imm = v.imm;
      req_rs2_data = v.rs2; cur_vl = v.cvl; req_valid = 1'b1;
   endtask

   task automatic chk_no_pulse(input string name);
      chk(name, 32'({vl_wr_en, vtype_wr_en, vstart_wr_en}), 32'd0);
   endtask

   task automatic chk_reset_vals(input string name);
      chk({name, "_ready"}, 32'(req_ready), 32'd1);
      chk_no_pulse({name, "_we"});
      chk({name, "_rvalid"}, 32'(resp_valid), 32'd0);
      chk({name, "_vl"}, 32'(vl_data), 32'd16);
      chk({name, "_vtype"}, 32'(vtype_data), 32'h0C0);
      chk({name, "_rd"}, resp_rd_data, 32'd0);
   endtask

   // Handshake at edge N, CALC after N, write pulse at N+2, response at N+3.
   task automatic run_vec(input vec_t v, input int idx);
      drive(v);
      tick();
      req_valid = 1'b0;
      chk($sformatf("v%0d_calc_ready", idx), 32'(req_ready), 32'd0);
      chk_no_pulse($sformatf("v%0d_calc_we", idx));
      tick();
      chk($sformatf("v%0d_pulse", idx), 32'({vl_wr_en, vtype_wr_en, vstart_wr_en}), 32'd7);
      chk($sformatf("v%0d_vl", idx), 32'(vl_data), 32'(v.evl));
      chk($sformatf("v%0d_vtype", idx), 32'(vtype_data), 32'(v.evt));
      chk($sformatf("v%0d_commit_rvalid", idx), 32'(resp_valid), 32'd0);
      tick();
      chk_no_pulse($sformatf("v%0d_resp_we", idx));
      chk($sformatf("v%0d_rvalid", idx), 32'(resp_valid), 32'd1);
      chk($sformatf("v%0d_rd_data", idx), resp_rd_data, 32'(v.evl));
      chk($sformatf("v%0d_rd_we", idx), 32'(resp_rd_wr_en), 32'(v.ewe));
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      chk($sformatf("v%0d_idle_ready", idx), 32'(req_ready), 32'd1);
      chk($sformatf("v%0d_idle_rvalid", idx), 32'(resp_valid), 32'd0);
   endtask

   initial begin
      //          op     rd0  rs10 rs1           uimm   imm     rs2           cvl  evl    evt     ewe
      vecs.push_back(mk(2'b00, 0, 0, 32'd20,        5'd0,  9'h011, 32'h0,        8'd0,  8'd8,   9'h011, 1));
      vecs.push_back(mk(2'b01, 1, 0, 32'd0,         5'd3,  9'h000, 32'h0,        8'd0,  8'd3,   9'h000, 0));
      vecs.push_back(mk(2'b10, 0, 0, 32'd5,         5'd0,  9'h000, 32'h200,      8'd0,  8'd0,   9'h100, 1));
      vecs.push_back(mk(2'b00, 0, 0, 32'd5,         5'd0,  9'h01D, 32'h0,        8'd0,  8'd0,   9'h100, 1));
      vecs.push_back(mk(2'b00, 0, 1, 32'd0,         5'd0,  9'h003, 32'h0,        8'd0,  8'h80,  9'h003, 1));
      vecs.push_back(mk(2'b00, 1, 1, 32'd0,         5'd0,  9'h010, 32'h0,        8'd16, 8'd4,   9'h010, 0));
      vecs.push_back(mk(2'b10, 0, 0, 32'd100,       5'd0,  9'h000, 32'h0D3,      8'd0,  8'd32,  9'h0D3, 1));
      vecs.push_back(mk(2'b00, 0, 0, 32'h103,       5'd0,  9'h000, 32'h0,        8'd0,  8'd16,  9'h000, 1));
      vecs.push_back(mk(2'b00, 0, 0, 32'h80000000,  5'd0,  9'h00F, 32'h0,        8'd0,  8'd4,   9'h00F, 1));
      vecs.push_back(mk(2'b00, 0, 0, 32'd5,         5'd0,  9'h004, 32'h0,        8'd0,  8'd0,   9'h100, 1));
      vecs.push_back(mk(2'b00, 0, 0, 32'd5,         5'd0,  9'h020, 32'h0,        8'd0,  8'd0,   9'h100, 1));
      vecs.push_back(mk(2'b11, 0, 0, 32'd5,         5'd0,  9'h000, 32'h0,        8'd0,  8'd0,   9'h100, 1));
      vecs.push_back(mk(2'b01, 0, 0, 32'd0,         5'd31, 9'h000, 32'h0,        8'd0,  8'd16,  9'h000, 1));
      vecs.push_back(mk(2'b01, 0, 1, 32'd0,         5'd5,  9'h000, 32'h0,        8'd0,  8'd5,   9'h000, 1));
      vecs.push_back(mk(2'b00, 0, 0, 32'd16,        5'd0,  9'h000, 32'h0,        8'd0,  8'd16,  9'h000, 1));
      vecs.push_back(mk(2'b00, 1, 1, 32'd0,         5'd0,  9'h000, 32'h0,        8'd3,  8'd3,   9'h000, 0));
      vecs.push_back(mk(2'b10, 0, 0, 32'hFF,        5'd0,  9'h000, 32'h0,        8'd0,  8'd16,  9'h000, 1));
      vecs.push_back(mk(2'b10, 0, 0, 32'hFF,        5'd0,  9'h000, 32'h100,      8'd0,  8'd0,   9'h100, 1));
      vecs.push_back(mk(2'b00, 0, 0, 32'd1,         5'd0,  9'h018, 32'h0,        8'd0,  8'd1,   9'h018, 1));

      rst = 1'b1; req_valid = 1'b0; req_op = '0; req_rd_x0 = 1'b0; req_rs1_x0 = 1'b0;
      req_rs1_data = '0; req_uimm = '0; req_vtype_imm = '0; req_rs2_data = '0;
      cur_vl = '0; flush = 1'b0; resp_ready = 1'b0;
      tick();
      tick();
      chk_reset_vals("reset");
      rst = 1'b0;
      tick();
      chk_reset_vals("post_reset");

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

      // Back-pressure: a second request waits while the response is stalled.
      drive(vecs[0]);
      tick();
      drive(vecs[4]);
      chk("bb_calc_ready", 32'(req_ready), 32'd0);
      tick();
      chk("bb_a_vl", 32'(vl_data), 32'd8);
      for (int c = 0; c < 5; c++) begin
         tick();
         chk($sformatf("bb_stall%0d_ready", c), 32'(req_ready), 32'd0);
         chk($sformatf("bb_stall%0d_rvalid", c), 32'(resp_valid), 32'd1);
         chk($sformatf("bb_stall%0d_rd", c), resp_rd_data, 32'd8);
         chk($sformatf("bb_stall%0d_vtype", c), 32'(vtype_data), 32'h011);
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      chk("bb_idle_ready", 32'(req_ready), 32'd1);
      chk("bb_idle_rvalid", 32'(resp_valid), 32'd0);
      tick();
      req_valid = 1'b0;
      chk("bb_b_calc_ready", 32'(req_ready), 32'd0);
      tick();
      chk("bb_b_pulse", 32'(vl_wr_en), 32'd1);
      chk("bb_b_vl", 32'(vl_data), 32'h80);
      tick();
      chk("bb_b_rd", resp_rd_data, 32'h80);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      chk("bb_b_done_ready", 32'(req_ready), 32'd1);

      // Reset while in CALC.
      drive(vecs[0]);
      tick();
      req_valid = 1'b0;
      chk("rstcalc_in_calc", 32'(req_ready), 32'd0);
      rst = 1'b1;
      #1;
      chk_reset_vals("rstcalc");
      #2;
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk_no_pulse($sformatf("rstcalc_after%0d_we", c));
         chk($sformatf("rstcalc_after%0d_ready", c), 32'(req_ready), 32'd1);
      end

      // Flush during COMMIT after a completed op left non-reset outputs.
      run_vec(vecs[6], 100);
      drive(vecs[0]);
      tick();
      req_valid = 1'b0;
      tick();
      flush = 1'b1;
      #1;
      chk_no_pulse("flcommit_gated_we");
      tick();
      flush = 1'b0;
      chk_reset_vals("flcommit");
      for (int c = 0; c < 3; c++) begin
         tick();
         chk_no_pulse($sformatf("flcommit_after%0d_we", c));
      end

      // Flush while holding a response.
      drive(vecs[1]);
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      chk("flresp_rvalid_before", 32'(resp_valid), 32'd1);
      flush = 1'b1;
      #1;
      chk("flresp_rvalid_dropped", 32'(resp_valid), 32'd0);
      tick();
      flush = 1'b0;
      chk("flresp_idle_ready", 32'(req_ready), 32'd1);
      chk("flresp_idle_rvalid", 32'(resp_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
